// File: rtl/io_bridge_if.sv
// io_bridge_if: bundles the core memory port, RAM port and UART
// handshakes that io_bridge sits between.
interface io_bridge_if;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        ram_we;
  logic [16:0] ram_a;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;
  logic        tx_overflow;

  modport master (
    output rdy_in, mem_a, mem_wr, mem_dout,
    output ram_rdata, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, ram_we, ram_a,
    input  ram_wdata, tx_data, tx_valid, rx_pop,
    input  program_stop, tx_overflow
  );

  modport slave (
    input  rdy_in, mem_a, mem_wr, mem_dout,
    input  ram_rdata, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, ram_we, ram_a,
    output ram_wdata, tx_data, tx_valid, rx_pop,
    output program_stop, tx_overflow
  );
endinterface

// File: rtl/io_bridge.sv
// io_bridge: RAM / memory-mapped IO decode, UART TX FIFO, RX latch, cycle counter.
// Optional IO_BRIDGE_CLK_SNAPSHOT_EN makes 0x30004..7 a coherent counter snapshot.
module io_bridge #(
  parameter int TX_DEPTH_LOG = 4,
  parameter int FULL_MARGIN  = 2
) (
  input logic       clk_in,
  input logic       rst_in,
  io_bridge_if.slave bus
);
  localparam int AW    = TX_DEPTH_LOG;
  localparam int DEPTH = 1 << TX_DEPTH_LOG;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_RX,
    SRC_CNT
  } src_t;

  logic        is_io;
  logic [15:0] off;
  logic        io_wr;
  logic        io_rd;
  logic        rd;
  logic        wr_tx;
  logic        wr_stop;
  logic        push_req;
  logic [7:0]  push_data;
  logic        rd_rx;
  logic        rd_cnt;
  logic        unused_hi;

  assign is_io     = bus.mem_a[17:16] == 2'b11;
  assign off       = bus.mem_a[15:0];
  assign unused_hi = ^bus.mem_a[31:18];
  assign rd        = bus.rdy_in & ~bus.mem_wr;
  assign io_wr     = bus.rdy_in & is_io & bus.mem_wr;
  assign io_rd     = rd & is_io;

  assign bus.ram_a     = bus.mem_a[16:0];
  assign bus.ram_wdata = bus.mem_dout;
  assign bus.ram_we    = bus.rdy_in & bus.mem_wr & ~is_io;

  // A zero byte on the data port is a no-op; the stop port always queues 0x00.
  assign wr_tx     = io_wr & (off == 16'h0) & (bus.mem_dout != 8'h00);
  assign wr_stop   = io_wr & (off == 16'h4);
  assign push_req  = wr_tx | wr_stop;
  assign push_data = wr_stop ? 8'h00 : bus.mem_dout;

  assign rd_rx      = io_rd & (off == 16'h0);
  assign rd_cnt     = io_rd & (off[15:2] == 14'h1);
  assign bus.rx_pop = rd_rx & bus.rx_valid;

  logic [7:0]  fifo [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0] cnt_q;
  logic [AW:0] free;
  logic        full;
  logic        push_ok;
  logic        pop;
  logic        ibf_q;
  logic        ovf_q;
  logic        stop_q;

  assign full         = cnt_q == DEPTH_C;
  assign free         = DEPTH_C - cnt_q;
  assign push_ok      = push_req & ~full;
  assign bus.tx_valid = cnt_q != '0;
  assign bus.tx_data  = fifo[rp];
  assign pop          = bus.tx_valid & bus.tx_ready;

  always_ff @(posedge clk_in) begin
    if (push_ok) fifo[wp] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wp     <= '0;
      rp     <= '0;
      cnt_q  <= '0;
      ibf_q  <= 1'b0;
      ovf_q  <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      ibf_q <= int'(free) <= FULL_MARGIN;
      if (push_req & full) ovf_q <= 1'b1;
      if (wr_stop) stop_q <= 1'b1;
    end
  end

  assign bus.io_buffer_full = ibf_q;
  assign bus.tx_overflow    = ovf_q;
  assign bus.program_stop   = stop_q;

  logic [31:0] clk_cnt;
  logic [7:0]  cnt_byte;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) clk_cnt <= '0;
    else if (bus.rdy_in) clk_cnt <= clk_cnt + 32'd1;
  end

  function automatic logic [7:0] byte_of(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

`ifdef IO_BRIDGE_CLK_SNAPSHOT_EN
  logic [31:0] snap;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) snap <= '0;
    else if (rd_cnt && off[1:0] == 2'd0) snap <= clk_cnt;
  end

  // Byte 0 comes straight from the counter being copied into snap.
  assign cnt_byte = (off[1:0] == 2'd0) ? clk_cnt[7:0]
                                       : byte_of(snap, off[1:0]);
`else
  assign cnt_byte = byte_of(clk_cnt, off[1:0]);
`endif

  src_t       src_q;
  logic [7:0] rx_q;
  logic [7:0] cb_q;
  logic       rd_live;
  logic [7:0] hold;
  logic [7:0] din;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      src_q   <= SRC_RAM;
      rx_q    <= '0;
      cb_q    <= '0;
      rd_live <= 1'b0;
      hold    <= '0;
    end else begin
      rd_live <= rd;
      hold    <= din;
      if (rd) begin
        unique case (1'b1)
          ~is_io: src_q <= SRC_RAM;
          rd_rx: begin
            src_q <= SRC_RX;
            rx_q  <= bus.rx_valid ? bus.rx_data : 8'h00;
          end
          rd_cnt: begin
            src_q <= SRC_CNT;
            cb_q  <= cnt_byte;
          end
          default: begin
            src_q <= SRC_RX;
            rx_q  <= 8'h00;
          end
        endcase
      end
    end
  end

  // Outside a read-return cycle the last presented byte is held.
  always_comb begin
    din = hold;
    if (rd_live) begin
      case (src_q)
        SRC_RAM: din = bus.ram_rdata;
        SRC_RX:  din = rx_q;
        SRC_CNT: din = cb_q;
        default: din = hold;
      endcase
    end
  end

  assign bus.mem_din = din;
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed stimulus with queued expectations for mem_din
// and tx_data, checked by an independent monitor.
module tb_io_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  io_bridge_if b ();

  io_bridge #(.TX_DEPTH_LOG(4), .FULL_MARGIN(2)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (b)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_m [int];
  always @(posedge clk) begin
    logic [7:0] t;
    t = ram_m.exists(int'(b.ram_a)) ? ram_m[int'(b.ram_a)] : 8'h00;
    if (b.ram_we) ram_m[int'(b.ram_a)] = b.ram_wdata;
    b.ram_rdata <= t;
  end

  logic       want = 1'b0;
  logic       want_q;
  logic [7:0] rd_exp [$];
  logic [7:0] tx_exp [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) want_q <= 1'b0;
    else want_q <= want;
  end

  always @(negedge clk) begin
    if (want_q) begin
      if (rd_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_queue: read return with no expectation");
      end else chk("mem_din", 32'(b.mem_din), 32'(rd_exp.pop_front()));
    end
    if (!rst && b.tx_valid && b.tx_ready) begin
      if (tx_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_unexpected: got %h expected none", b.tx_data);
      end else chk("tx_data", 32'(b.tx_data), 32'(tx_exp.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b.rdy_in = 1'b1;
    b.mem_a = 32'h0;
    b.mem_wr = 1'b0;
    b.mem_dout = 8'h00;
    want = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    b.rdy_in = 1'b1;
    b.mem_a = a;
    b.mem_wr = 1'b1;
    b.mem_dout = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e);
    b.rdy_in = 1'b1;
    b.mem_a = a;
    b.mem_wr = 1'b0;
    want = 1'b1;
    rd_exp.push_back(e);
    step();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b.rdy_in = 1'b0;
    want = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b.rdy_in = 1'b0; b.mem_a = '0; b.mem_wr = 1'b0; b.mem_dout = '0;
    b.tx_ready = 1'b0; b.rx_data = '0; b.rx_valid = 1'b0;
    #1;
    chk("rst_mem_din", 32'(b.mem_din), 0);
    chk("rst_ibf", 32'(b.io_buffer_full), 0);
    chk("rst_tx_valid", 32'(b.tx_valid), 0);
    chk("rst_stop", 32'(b.program_stop), 0);
    chk("rst_ovf", 32'(b.tx_overflow), 0);
    do_reset();

    // RAM write then read back, then hold with rdy low
    b.rdy_in = 1'b1; b.mem_a = 32'h100; b.mem_wr = 1'b1; b.mem_dout = 8'hA5;
    #1;
    chk("ram_we_wr", 32'(b.ram_we), 1);
    chk("ram_a", 32'(b.ram_a), 32'h100);
    chk("ram_wdata", 32'(b.ram_wdata), 32'hA5);
    step();
    b.mem_wr = 1'b0; want = 1'b1; rd_exp.push_back(8'hA5);
    #1;
    chk("ram_we_rd", 32'(b.ram_we), 0);
    step();
    want = 1'b0; b.rdy_in = 1'b0; b.mem_a = 32'h200; b.mem_wr = 1'b1;
    #1;
    chk("ram_we_rdy_low", 32'(b.ram_we), 0);
    step();
    chk("mem_din_hold1", 32'(b.mem_din), 32'hA5);
    step();
    chk("mem_din_hold2", 32'(b.mem_din), 32'hA5);
    idle();
    wr(32'h1FFFF, 8'h5C);
    rd(32'h1FFFF, 8'h5C);

    // TX: zero byte skipped, ordered drain
    b.tx_ready = 1'b0;
    wr(32'h30000, 8'h41); tx_exp.push_back(8'h41);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h42); tx_exp.push_back(8'h42);
    chk("tx_valid_two", 32'(b.tx_valid), 1);
    chk("ibf_two", 32'(b.io_buffer_full), 0);
    b.tx_ready = 1'b1;
    repeat (3) step();
    chk("tx_valid_drained", 32'(b.tx_valid), 0);
    chk("tx_q_empty1", 32'(tx_exp.size()), 0);
    b.tx_ready = 1'b0;
    wr(32'h30008, 8'h33);
    step();
    chk("tx_other_off", 32'(b.tx_valid), 0);

    // Fill to depth, watch registered nearly-full, overflow
    for (int i = 1; i <= 16; i++) begin
      b.rdy_in = 1'b1; b.mem_a = 32'h30000; b.mem_wr = 1'b1;
      b.mem_dout = 8'(i);
      tx_exp.push_back(8'(i));
      step();
      chk($sformatf("ibf_%0d", i), 32'(b.io_buffer_full),
          32'((i - 1) >= 14));
    end
    chk("ovf_before", 32'(b.tx_overflow), 0);
    wr(32'h30000, 8'h77);
    chk("ovf_set", 32'(b.tx_overflow), 1);
    chk("ibf_full", 32'(b.io_buffer_full), 1);
    b.tx_ready = 1'b1;
    repeat (17) step();
    chk("tx_valid_after_full", 32'(b.tx_valid), 0);
    chk("tx_q_empty2", 32'(tx_exp.size()), 0);
    chk("ovf_sticky", 32'(b.tx_overflow), 1);
    chk("ibf_clear", 32'(b.io_buffer_full), 0);
    b.tx_ready = 1'b0;

    // Counter with a freeze window, then byte reads
    do_reset();
    chk("ovf_rst", 32'(b.tx_overflow), 0);
    idle();
    repeat (32'h1000) step();
    b.rdy_in = 1'b0;
    repeat (7) step();
    b.rdy_in = 1'b1;
    repeat (32'h234) step();
    rd(32'h30004, 8'h34);
    rd(32'h30005, 8'h12);
    rd(32'h30006, 8'h00);
    rd(32'h30007, 8'h00);

    // RX latch and pop
    b.rx_valid = 1'b1; b.rx_data = 8'h7E;
    b.mem_a = 32'h30000; want = 1'b1; rd_exp.push_back(8'h7E);
    #1;
    chk("rx_pop_on", 32'(b.rx_pop), 1);
    step();
    b.rx_valid = 1'b0; rd_exp.push_back(8'h00);
    #1;
    chk("rx_pop_empty", 32'(b.rx_pop), 0);
    step();
    idle();
    b.rx_valid = 1'b1;
    #1;
    chk("rx_pop_ram", 32'(b.rx_pop), 0);
    b.rdy_in = 1'b0; b.mem_a = 32'h30000;
    #1;
    chk("rx_pop_rdy_low", 32'(b.rx_pop), 0);
    b.rx_valid = 1'b0;
    idle();
    rd(32'h30010, 8'h00);

    // Stop write then reset mid-drain
    wr(32'h30000, 8'h55); tx_exp.push_back(8'h55);
    wr(32'h30004, 8'h99);
    chk("stop_set", 32'(b.program_stop), 1);
    b.tx_ready = 1'b1;
    step();
    chk("zero_queued", 32'(b.tx_valid), 1);
    chk("zero_byte", 32'(b.tx_data), 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_valid", 32'(b.tx_valid), 0);
    chk("rst_mid_stop", 32'(b.program_stop), 0);
    chk("rst_mid_din", 32'(b.mem_din), 0);
    chk("rst_mid_ibf", 32'(b.io_buffer_full), 0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("fifo_empty_after", 32'(b.tx_valid), 0);
    chk("tx_q_empty3", 32'(tx_exp.size()), 0);
    chk("rd_q_empty", 32'(rd_exp.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
